// File: rtl/bit32_div_seq.sv
// Iterative restoring divider (MIPS DIV/DIVU): one quotient bit per cycle, LO=quotient, HI=remainder.
// Optional macro BIT32_DIV_ZERO_ERR_EN adds a latched divide-by-zero flag on err_out.
module bit32_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ack_in,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out,
  output logic             err_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] rem_reg, dvd_reg, dsr_reg;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg, neg_r_reg;

  logic             accept, last_iter;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] op_raw [2];
  logic [WIDTH-1:0] op_mag [2];

  assign accept    = start_in && (state_reg == S_IDLE);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Operand 0 is the dividend, operand 1 the divisor; 0x80000000 stays 2^31 as an unsigned magnitude.
  assign op_raw[0] = A_in;
  assign op_raw[1] = B_in;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mag
      assign op_mag[gi] = (signed_in && op_raw[gi][WIDTH-1]) ? -op_raw[gi] : op_raw[gi];
    end
  endgenerate

  // The dividend register doubles as the quotient accumulator: bits shift out the top, q bits in at the bottom.
  assign rem_sh = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dsr_reg};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_in) state_next = S_BUSY;
      S_BUSY:  if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  if (ack_in) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state_reg == S_IDLE);
    valid_out = (state_reg == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            dvd_reg   <= op_mag[0];
            dsr_reg   <= op_mag[1];
            rem_reg   <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= signed_in && (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            neg_r_reg <= signed_in && A_in[WIDTH-1];
          end
        end
        S_BUSY: begin
          rem_reg <= trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
          dvd_reg <= {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_FIX: begin
          q_reg <= neg_q_reg ? -dvd_reg : dvd_reg;
          r_reg <= neg_r_reg ? -rem_reg : rem_reg;
        end
        default: ;
      endcase
    end
  end

  assign Q_out = q_reg;
  assign R_out = r_reg;

`ifdef BIT32_DIV_ZERO_ERR_EN
  logic err_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_reg <= 1'b0;
    end else if (accept) begin
      err_reg <= (B_in == '0);
    end
  end

  assign err_out = err_reg;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: doc/bit32_div_seq.md
Name: bit32_div_seq

Overview:
- Iterative 32-bit divider for the RISC32i_CPU execute stage; implements MIPS DIV and DIVU.
- Produces the quotient (LO) and remainder (HI).
- Built on restoring subtract-and-shift, one quotient bit per cycle.
- Sits beside the combinational add/sub ALU. A valid/ready handshake lets the pipeline stall on issue and on result pickup.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request; accepted when start_in & ready_out are both high at a rising edge.
- signed_in  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at accept.
- A_in  input  WIDTH  dividend; sampled at accept.
- B_in  input  WIDTH  divisor; sampled at accept.
- ready_out  output  1  high only in IDLE.
- valid_out  output  1  result available; high only in DONE.
- ack_in  input  1  result consumed; DONE->IDLE when valid_out & ack_in at an edge.
- Q_out  output  WIDTH  quotient (LO).
- R_out  output  WIDTH  remainder (HI).
- err_out  output  1  divide-by-zero flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ready_out=1, valid_out=0.
  - Q_out=0, R_out=0, err_out=0, counter=0.
- States:
  - IDLE: accept on start_in & ready_out.
    - Latch |A| and |B|. Magnitudes are used only if signed_in=1 and the operand MSB=1; otherwise the raw operands.
    - Latch neg_q = signed & (A[31]^B[31]) and neg_r = signed & A[31].
    - Clear the partial remainder and counter; go to BUSY.
  - BUSY: each cycle:
    - rem = {rem[30:0], dvd[31]}; shift dvd left.
    - Trial = {1'b0,rem} - {1'b0,divisor}, 33-bit.
    - If no borrow: rem = trial, q bit = 1; else q bit = 0.
    - After the WIDTH-th iteration, go to FIX.
  - FIX: 1 cycle.
    - Q_out = neg_q ? -q : q.
    - R_out = neg_r ? -rem : rem.
    - Go to DONE.
  - DONE: valid_out=1; Q_out/R_out/err_out held stable until ack_in.
    - On ack, go to IDLE; Q_out/R_out keep their last value.
- Latency: accept at edge k; valid_out rises after edge k+WIDTH+1 (k+33 at default). Fixed for all operands, including divide-by-zero.
- Throughput: at most one operation per WIDTH+3 cycles. ack_in may be held high continuously; the next start may be accepted the cycle after return to IDLE.
- start_in while not ready_out is ignored. Operands are not re-sampled.
- ack_in outside DONE is ignored.
- Divisor 0 takes the natural algorithm result:
  - Unsigned: Q=0xFFFFFFFF, R=A.
  - Signed: sign fix applied, so A=5 gives Q=0xFFFFFFFF, R=5; A=-5 gives Q=0x00000001, R=-5.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Q=0x80000000, R=0 (wraps). No error.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31.
- Reset mid-operation: immediate return to IDLE with reset values; the in-flight result is discarded.

Optional Feature:
- Macro BIT32_DIV_ZERO_ERR_EN.
- When defined:
  - err_out latched at accept as (B_in==0).
  - Held through DONE; cleared on the next accept.
  - Q_out/R_out values unchanged from the non-error definition.
- When undefined: err_out tied to 0; no extra flop.

Test Plan:
- DIVU A=100, B=7, start pulse at edge k -> ready_out low from k+1, valid_out high after k+33; Q=14, R=2; ack -> ready_out=1 next cycle.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1).
  - Also A=7, B=-2 -> Q=-3, R=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, err_out=0.
  - DIVU same operands -> Q=0, R=0x80000000.
- DIVU A=5, B=0 -> Q=0xFFFFFFFF, R=5, latency 33.
  - err_out=1 with BIT32_DIV_ZERO_ERR_EN, 0 without.
  - Next op A=9, B=3 clears err_out.
- Backpressure and ignored input: hold ack_in=0 for 10 cycles after valid -> outputs stable, valid_out stays high. A start_in pulse with new operands during BUSY/DONE -> ignored.
- Reset mid-op: assert rst_n_in=0 at iteration 12 -> ready_out=1, valid_out=0, Q/R=0 immediately without clock. Release, then a new op A=1000, B=10 -> Q=100, R=0.
